// File: rtl/tetris_uart_pkg.sv
// Shared types and constants for the game-event UART transmitter.
//   event_t      : game event codes carried in packet byte 1
//   SYNC_BYTE    : first byte of every packet
//   PKT_LEN      : bytes per packet
//   fmt_state_t  : packet formatter states
//   tx_state_t   : UART byte-sender states
//   pkt_byte()   : byte idx of the packet for a latched event
package tetris_uart_pkg;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LINE     = 3'd1,
    EV_GAMEOVER = 3'd2,
    EV_SPAWN    = 3'd3,
    EV_LEVEL    = 3'd4
  } event_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_LEN   = 5;

  typedef enum logic {
    FmtIdle,
    FmtWrite
  } fmt_state_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxLoad,
    TxSend,
    TxWaitDrop
  } tx_state_t;

  // Packet: sync, {type,row}, score hi, score lo, xor of the first four.
  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input event_t      ev,
                                          input logic [4:0]  row,
                                          input logic [15:0] score);
    logic [7:0] b1;
    b1 = {ev, row};
    case (idx)
      3'd0:    pkt_byte = SYNC_BYTE;
      3'd1:    pkt_byte = b1;
      3'd2:    pkt_byte = score[15:8];
      3'd3:    pkt_byte = score[7:0];
      default: pkt_byte = SYNC_BYTE ^ b1 ^ score[15:8] ^ score[7:0];
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with head/tail pointers and an occupancy counter.
//   clk    : system clock
//   rst    : synchronous active-low reset (empties the FIFO)
//   push   : write wdata at tail (ignored when full)
//   wdata  : byte to write
//   pop    : advance head (ignored when empty)
//   rdata  : byte at head, combinational
//   empty  : no bytes stored
//   count  : occupancy, 0..DEPTH
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= tail_q + AW'(1);
      if (pop_ok)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[head_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/tetris_uart_tx.sv
// Game-event transmitter: frames one-cycle game events into 5-byte packets,
// buffers them in a byte FIFO and drains it over the board tx handshake.
//   clk         : system clock
//   rst         : synchronous active-low reset
//   event_valid : event offered this cycle
//   event_ready : formatter idle and room for a whole packet
//   event_type  : event code
//   event_row   : grid row for line clears, else 0
//   score       : current score, latched at acceptance
//   txdata      : byte presented to the UART, held until the next load
//   txclk       : one-cycle send strobe
//   txready     : UART idle and able to take a byte
//   drop_count  : saturating count of events offered while not ready
module tetris_uart_tx
  import tetris_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        event_valid,
  output logic        event_ready,
  input  event_t      event_type,
  input  logic [4:0]  event_row,
  input  logic [15:0] score,
  output logic [7:0]  txdata,
  output logic        txclk,
  input  logic        txready,
  output logic [7:0]  drop_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fmt_state_t    fmt_state_q, fmt_state_d;
  logic [2:0]    idx_q, idx_d;
  event_t        pkt_type_q;
  logic [4:0]    pkt_row_q;
  logic [15:0]   pkt_score_q;

  tx_state_t     tx_state_q, tx_state_d;
  logic [7:0]    txdata_q, txdata_d;
  logic [7:0]    drop_q;

  logic          fifo_push, fifo_pop, fifo_empty;
  logic [7:0]    fifo_wdata, fifo_rdata;
  logic [CW-1:0] fifo_count, fifo_free;
  logic          accept;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Room for a full packet is reserved up front so the formatter never stalls.
  assign fifo_free   = CW'(DEPTH) - fifo_count;
  assign event_ready = (fmt_state_q == FmtIdle) && (fifo_free >= CW'(PKT_LEN));
  assign accept      = event_valid && event_ready;

  // Formatter: one packet byte pushed per cycle while writing.
  always_comb begin
    fmt_state_d = fmt_state_q;
    idx_d       = idx_q;
    fifo_push   = 1'b0;
    fifo_wdata  = pkt_byte(idx_q, pkt_type_q, pkt_row_q, pkt_score_q);
    unique case (fmt_state_q)
      FmtIdle: begin
        if (accept) begin
          fmt_state_d = FmtWrite;
          idx_d       = 3'd0;
        end
      end
      FmtWrite: begin
        fifo_push = 1'b1;
        if (idx_q == 3'(PKT_LEN - 1)) begin
          fmt_state_d = FmtIdle;
          idx_d       = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: fmt_state_d = FmtIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fmt_state_q <= FmtIdle;
      idx_q       <= 3'd0;
      pkt_type_q  <= EV_NONE;
      pkt_row_q   <= 5'd0;
      pkt_score_q <= 16'd0;
    end else begin
      fmt_state_q <= fmt_state_d;
      idx_q       <= idx_d;
      if (accept) begin
        pkt_type_q  <= event_type;
        pkt_row_q   <= event_row;
        pkt_score_q <= score;
      end
    end
  end

  // Byte sender. The head byte is captured and popped on the edge that enters
  // TxLoad, so txdata is settled a full cycle before the strobe in TxSend.
  always_comb begin
    tx_state_d = tx_state_q;
    txdata_d   = txdata_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (!fifo_empty && txready) begin
          txdata_d   = fifo_rdata;
          fifo_pop   = 1'b1;
          tx_state_d = TxLoad;
        end
      end
      TxLoad:     tx_state_d = TxSend;
      TxSend:     tx_state_d = TxWaitDrop;
      // Wait for the UART to acknowledge by dropping txready.
      TxWaitDrop: if (!txready) tx_state_d = TxIdle;
      default:    tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      txdata_q   <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      txdata_q   <= txdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= 8'd0;
    end else if (event_valid && !event_ready && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign txdata     = txdata_q;
  assign txclk      = (tx_state_q == TxSend);
  assign drop_count = drop_q;

endmodule
